// File: rtl/fma_special_flags_pkg.sv
// fma_special_pkg: shared definitions for the FMA special-case/flag stage.
//   - flag bit positions inside the 4-bit {NV, OF, UF, NX} flag vector
//   - rounding-mode encodings (values 5..7 fall back to RNE)
//   - fpClass_t: operand classification produced by fp_classify
package fma_special_pkg;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RZ  = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
    logic subnorm;
  } fpClass_t;

endpackage

// File: rtl/fma_special_flags_if.sv
// fma_special_flags_if: operation/result bus of the FMA special-case stage.
//   master : producer of operations and consumer of results (drives in_*, out_ready, flags_clr)
//   slave  : the fma_special_flags block
interface fma_special_flags_if #(
  parameter int EW = 5,
  parameter int MW = 10
);
  localparam int W = 1 + EW + MW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y, z;
  logic [W-1:0] sum;
  logic         sum_inexact;
  logic         sum_ovf;
  logic         sum_tiny;
  logic [2:0]   rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic [3:0]   fflags_acc;
  logic         flags_clr;

  modport master (
    output in_valid, x, y, z, sum, sum_inexact, sum_ovf, sum_tiny, rm, out_ready, flags_clr,
    input  in_ready, out_valid, out_result, out_flags, fflags_acc
  );

  modport slave (
    input  in_valid, x, y, z, sum, sum_inexact, sum_ovf, sum_tiny, rm, out_ready, flags_clr,
    output in_ready, out_valid, out_result, out_flags, fflags_acc
  );
endinterface

// File: rtl/fma_special_flags_fp_classify.sv
// fp_classify: combinational IEEE-style classifier for one operand.
//   op  : operand {sign, exponent[EW], mantissa[MW]}
//   cls : {zero, inf, nan, snan, subnorm}
module fp_classify
  import fma_special_pkg::*;
#(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic [EW+MW:0] op,
  output fpClass_t       cls
);
  logic [EW-1:0] exp;
  logic [MW-1:0] man;
  logic          expOnes, expZero, manZero;

  assign exp     = op[EW+MW-1:MW];
  assign man     = op[MW-1:0];
  assign expOnes = &exp;
  assign expZero = ~|exp;
  assign manZero = ~|man;

  assign cls.zero    = expZero & manZero;
  assign cls.subnorm = expZero & ~manZero;
  assign cls.inf     = expOnes & manZero;
  assign cls.nan     = expOnes & ~manZero;
  // signalling NaN: quiet bit (mantissa MSB) clear
  assign cls.snan    = expOnes & ~manZero & ~man[MW-1];
endmodule

// File: rtl/fma_special_flags.sv
// fma_special_flags: two-stage special-case override and IEEE flag stage
// behind the FMA add/round datapath (result = x*y+z).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready + x,y,z,sum,sum_inexact,sum_ovf,sum_tiny,rm;
//                  out_valid/out_ready + out_result,out_flags {NV,OF,UF,NX};
//                  fflags_acc (sticky flags), flags_clr
// Stage 1 registers operands/datapath info/classes; stage 2 registers the
// resolved result and flags. Full valid/ready backpressure, 1 op/cycle.
// Build option FMA_SPECIAL_NAN_PROP_EN: propagate the first NaN operand
// (x, y, z order, quieted) instead of returning the canonical qNaN.
module fma_special_flags
  import fma_special_pkg::*;
#(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  fma_special_flags_if.slave bus
);
  localparam int W = 1 + EW + MW;
  localparam logic [W-2:0] INF_MAG = {{EW{1'b1}}, {MW{1'b0}}};
  localparam logic [W-2:0] MAX_MAG = {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
  localparam logic [W-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  // vldPipe[1] = stage 1 occupied, vldPipe[2] = stage 2 occupied
  logic [2:1]            vldPipe;
  logic                  s1Adv, s2Adv, xfer;

  logic [2:0][W-1:0]     opsIn;
  fpClass_t [2:0]        clsIn;
  fpClass_t [2:0]        s1Cls;
  logic [W-1:0]          s1X, s1Y, s1Z, s1Sum;
  logic                  s1Inx, s1Ovf, s1Tiny;
  logic [2:0]            s1Rm;

  logic [W-1:0]          res, outRes;
  logic [3:0]            flg, outFlags, acc;

  // index 0 = x, 1 = y, 2 = z
  assign opsIn = {bus.z, bus.y, bus.x};

  for (genvar i = 0; i < 3; i++) begin : gCls
    fp_classify #(.EW(EW), .MW(MW)) uCls (.op(opsIn[i]), .cls(clsIn[i]));
  end

  assign s2Adv = ~vldPipe[2] | bus.out_ready;
  assign s1Adv = ~vldPipe[1] | s2Adv;
  assign xfer  = vldPipe[2] & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vldPipe <= '0;
    end else begin
      if (s1Adv) vldPipe[1] <= bus.in_valid;
      if (s2Adv) vldPipe[2] <= vldPipe[1];
    end
  end

  always_ff @(posedge clk) begin
    if (s1Adv && bus.in_valid) begin
      s1X    <= bus.x;
      s1Y    <= bus.y;
      s1Z    <= bus.z;
      s1Sum  <= bus.sum;
      s1Inx  <= bus.sum_inexact;
      s1Ovf  <= bus.sum_ovf;
      s1Tiny <= bus.sum_tiny;
      s1Rm   <= bus.rm;
      s1Cls  <= clsIn;
    end
  end

  logic anyNan, anySnan, zeroInf, prodInf, prodSign, sumSign;

  assign anyNan   = s1Cls[0].nan  | s1Cls[1].nan  | s1Cls[2].nan;
  assign anySnan  = s1Cls[0].snan | s1Cls[1].snan | s1Cls[2].snan;
  assign zeroInf  = (s1Cls[0].zero & s1Cls[1].inf) | (s1Cls[0].inf & s1Cls[1].zero);
  assign prodInf  = s1Cls[0].inf | s1Cls[1].inf;
  assign prodSign = s1X[W-1] ^ s1Y[W-1];
  assign sumSign  = s1Sum[W-1];

`ifdef FMA_SPECIAL_NAN_PROP_EN
  logic [W-1:0] nanRes;
  always_comb begin
    nanRes = s1Cls[0].nan ? s1X : (s1Cls[1].nan ? s1Y : s1Z);
    nanRes[MW-1] = 1'b1;
  end
  logic unusedBits;
  assign unusedBits = ^{s1Cls[0].subnorm, s1Cls[1].subnorm, s1Cls[2].subnorm, s1Cls[2].zero};
`else
  logic [W-1:0] nanRes;
  assign nanRes = QNAN;
  logic unusedBits;
  assign unusedBits = ^{s1Cls[0].subnorm, s1Cls[1].subnorm, s1Cls[2].subnorm, s1Cls[2].zero,
                        s1X[W-2:0], s1Y[W-2:0]};
`endif

  // first match wins, see the if/else order below
  always_comb begin
    res = s1Sum;
    flg = '0;
    if (anyNan) begin
      res = nanRes;
      flg[FLAG_NV] = anySnan;
    end else if (zeroInf) begin
      res = QNAN;
      flg[FLAG_NV] = 1'b1;
    end else if (prodInf && s1Cls[2].inf && (prodSign != s1Z[W-1])) begin
      res = QNAN;
      flg[FLAG_NV] = 1'b1;
    end else if (prodInf) begin
      res = {prodSign, INF_MAG};
    end else if (s1Cls[2].inf) begin
      res = s1Z;
    end else if (s1Ovf) begin
      flg[FLAG_OF] = 1'b1;
      flg[FLAG_NX] = 1'b1;
      case (rm_e'(s1Rm))
        RM_RZ:   res = {sumSign, MAX_MAG};
        RM_RDN:  res = {sumSign, sumSign ? INF_MAG : MAX_MAG};
        RM_RUP:  res = {sumSign, sumSign ? MAX_MAG : INF_MAG};
        default: res = {sumSign, INF_MAG};  // RNE, RMM and unused encodings
      endcase
    end else begin
      flg[FLAG_NX] = s1Inx;
      flg[FLAG_UF] = s1Tiny & s1Inx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outRes   <= '0;
      outFlags <= '0;
    end else if (s2Adv && vldPipe[1]) begin
      outRes   <= res;
      outFlags <= flg;
    end
  end

  // clear takes effect before the same-cycle transfer is accrued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           acc <= '0;
    else if (bus.flags_clr) acc <= xfer ? outFlags : 4'd0;
    else if (xfer)          acc <= acc | outFlags;
  end

  assign bus.in_ready   = s1Adv;
  assign bus.out_valid  = vldPipe[2];
  assign bus.out_result = outRes;
  assign bus.out_flags  = outFlags;
  assign bus.fflags_acc = acc;
endmodule
